// File: rtl/acker_pwm_multi.sv
`default_nettype none
// ============================================================================
//  Module   : acker_pwm_multi
//  Brief    : Multi-channel PWM generator sharing one prescaled period
//             counter. Duty writes land in shadow registers and are copied
//             into the active set together at the period boundary.
//  Revision : 1.0 - initial release
// ============================================================================
module acker_pwm_multi #(
   parameter int WIDTH      = 8,
   parameter int CHANNELS   = 4,
   parameter int CH_W       = 2,
   parameter int PRESCALE_W = 8
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [PRESCALE_W-1:0] prescale,
   input  logic [CHANNELS-1:0]   power,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   input  logic [CH_W-1:0]       wr_channel,
   input  logic [WIDTH-1:0]      wr_duty,
   output logic [CHANNELS-1:0]   pending,
   output logic                  period_end,
   output logic [CHANNELS-1:0]   analogOutput
);

   logic [PRESCALE_W-1:0]              pdiv_q, pdiv_d;
   logic [WIDTH-1:0]                   count_q, count_d;
   logic [CHANNELS-1:0][WIDTH-1:0]     shadow_q, shadow_d;
   logic [CHANNELS-1:0][WIDTH-1:0]     active_q, active_d;
   logic [CHANNELS-1:0]                pending_q, pending_d;
   logic [CHANNELS-1:0]                out_q, out_d;
   logic                               period_end_q;

   logic w_tick;
   logic w_load;
   logic w_wr_fire;

   // Prescaler and period counter; '>=' lets a lowered prescale act at once.
   always_comb begin
      w_tick  = (pdiv_q >= prescale);
      w_load  = w_tick && (count_q == {WIDTH{1'b1}});
      pdiv_d  = w_tick ? '0 : pdiv_q + 1'b1;
      count_d = w_tick ? count_q + 1'b1 : count_q;
   end

   // Writes are refused in the load cycle and while reset is held.
   assign wr_ready  = reset & ~w_load;
   assign w_wr_fire = wr_valid & wr_ready;

   // Per-channel shadow/active bookkeeping and the output compare.
   // An out-of-range channel index matches no channel and is dropped.
   always_comb begin
      shadow_d  = shadow_q;
      active_d  = active_q;
      pending_d = pending_q;
      out_d     = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (w_load) begin
            if (pending_q[i]) begin
               active_d[i] = shadow_q[i];
            end
            pending_d[i] = 1'b0;
         end else if (w_wr_fire && (wr_channel == CH_W'(i))) begin
            shadow_d[i]  = wr_duty;
            pending_d[i] = 1'b1;
         end
         out_d[i] = (active_q[i] > count_q) & power[i];
      end
   end

   // State register; reset clears everything including un-loaded shadows.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pdiv_q       <= '0;
         count_q      <= '0;
         shadow_q     <= '0;
         active_q     <= '0;
         pending_q    <= '0;
         out_q        <= '0;
         period_end_q <= 1'b0;
      end else begin
         pdiv_q       <= pdiv_d;
         count_q      <= count_d;
         shadow_q     <= shadow_d;
         active_q     <= active_d;
         pending_q    <= pending_d;
         out_q        <= out_d;
         period_end_q <= w_load;
      end
   end

   assign pending      = pending_q;
   assign period_end   = period_end_q;
   assign analogOutput = out_q;

endmodule
`default_nettype wire

// File: tb/tb_acker_pwm_multi.sv
`default_nettype none
// ============================================================================
//  Module   : tb_acker_pwm_multi
//  Brief    : Directed self-checking bench for acker_pwm_multi with an
//             expected-value queue. CH_W is widened to 3 so that a channel
//             index beyond CHANNELS-1 can actually be driven.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_acker_pwm_multi;

   localparam int WIDTH = 8;
   localparam int CHN   = 4;
   localparam int CHW   = 3;
   localparam int PSW   = 8;

   logic             clock = 1'b0;
   logic             reset = 1'b0;
   logic [PSW-1:0]   prescale = '0;
   logic [CHN-1:0]   power = '1;
   logic             wr_valid = 1'b0;
   logic             wr_ready;
   logic [CHW-1:0]   wr_channel = '0;
   logic [WIDTH-1:0] wr_duty = '0;
   logic [CHN-1:0]   pending;
   logic             period_end;
   logic [CHN-1:0]   analogOutput;

   acker_pwm_multi #(
      .WIDTH(WIDTH), .CHANNELS(CHN), .CH_W(CHW), .PRESCALE_W(PSW)
   ) dut (
      .clock(clock), .reset(reset), .prescale(prescale), .power(power),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_channel(wr_channel),
      .wr_duty(wr_duty), .pending(pending), .period_end(period_end),
      .analogOutput(analogOutput)
   );

   always #5 clock = ~clock;

   typedef struct {
      string       tag;
      logic [31:0] exp;
   } exp_t;

   exp_t sb[$];
   int   tests  = 0;
   int   failed = 0;
   int   n_clk;
   int   hi [CHN];

   task automatic push(input string tag, input logic [31:0] e);
      exp_t x;
      x.tag = tag;
      x.exp = e;
      sb.push_back(x);
   endtask

   task automatic check(input logic [31:0] obs);
      exp_t x;
      tests++;
      if (sb.size() == 0) begin
         failed++;
         $display("FAIL scoreboard_empty: observed %0d with no expectation", obs);
      end else begin
         x = sb.pop_front();
         assert (obs === x.exp) else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", x.tag, obs, x.exp);
         end
      end
   endtask

   // Advance n clocks, leaving the bench 1 time unit after the last edge.
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   // Run until the next period_end pulse, counting clocks and high samples.
   task automatic wait_pe(input int bound);
      for (int c = 0; c < CHN; c++) hi[c] = 0;
      n_clk = 0;
      do begin
         step(1);
         n_clk++;
         for (int c = 0; c < CHN; c++) if (analogOutput[c]) hi[c]++;
      end while (!period_end && n_clk < bound);
      if (!period_end) n_clk = -1;
   endtask

   // Offer one write and hold it until accepted.
   task automatic wr(input int ch, input int d);
      int guard = 0;
      wr_valid   = 1'b1;
      wr_channel = CHW'(ch);
      wr_duty    = WIDTH'(d);
      while (!wr_ready && guard < 10) begin
         step(1);
         guard++;
      end
      step(1);
      wr_valid = 1'b0;
   endtask

   initial begin
      // Reset state
      step(3);
      push("rst_out", 0);        check(32'(analogOutput));
      push("rst_pending", 0);    check(32'(pending));
      push("rst_period_end", 0); check(32'(period_end));
      push("rst_wr_ready", 0);   check(32'(wr_ready));

      // First period_end 256 clocks after release, then every 256
      reset = 1'b1;
      wait_pe(1000);
      push("first_pe_clk", 256); check(32'(n_clk));
      push("idle_hi", 0);        check(32'(hi[0] + hi[1] + hi[2] + hi[3]));
      wait_pe(1000);
      push("second_pe_clk", 256); check(32'(n_clk));

      // Basic duty: nothing visible until the load
      wr(0, 64);
      wr(1, 192);
      push("basic_pending", 4'b0011); check(32'(pending));
      wait_pe(1000);
      push("basic_preload_hi", 0);    check(32'(hi[0] + hi[1]));
      push("basic_postload_pend", 0); check(32'(pending));
      wait_pe(1000);
      push("basic_ch0_hi", 64);  check(32'(hi[0]));
      push("basic_ch1_hi", 192); check(32'(hi[1]));

      // Double write to ch2 and a write to nonexistent channel 5
      wr(2, 10);
      wr(2, 200);
      wr(5, 77);
      push("dbl_pending", 4'b0100); check(32'(pending));
      wait_pe(1000);
      push("dbl_pending_after", 0); check(32'(pending));
      wait_pe(1000);
      push("dbl_ch2_hi", 200); check(32'(hi[2]));
      push("bad_ch0_hi", 64);  check(32'(hi[0]));
      push("bad_ch1_hi", 192); check(32'(hi[1]));
      push("bad_ch3_hi", 0);   check(32'(hi[3]));

      // Write in last tick (count 254), then hold a write across the load cycle
      step(254);
      push("last_tick_ready", 1); check(32'(wr_ready));
      wr_valid = 1'b1; wr_channel = 3'd0; wr_duty = 8'd30;
      step(1);
      push("load_cycle_ready", 0); check(32'(wr_ready));
      wr_channel = 3'd3; wr_duty = 8'd100;
      step(1);
      push("load_pe", 1);          check(32'(period_end));
      push("after_load_ready", 1); check(32'(wr_ready));
      push("after_load_pend", 0);  check(32'(pending));
      step(1);
      wr_valid = 1'b0;
      push("held_wr_pending", 4'b1000); check(32'(pending));
      wait_pe(1000);
      push("held_ch3_not_yet", 0); check(32'(hi[3]));
      wait_pe(1000);
      push("last_tick_ch0_hi", 30); check(32'(hi[0]));
      push("held_ch3_hi", 100);     check(32'(hi[3]));

      // Edge duties
      wr(0, 0);
      wr(1, 255);
      wait_pe(1000);
      wait_pe(1000);
      push("duty0_hi", 0);     check(32'(hi[0]));
      push("duty255_hi", 255); check(32'(hi[1]));

      // Drop power[3] mid-period: output 3 falls one clock later
      step(100);
      power[3] = 1'b0;
      push("pwr_before_edge", 1); check(32'(analogOutput[3]));
      step(1);
      push("pwr_after_edge", 4'b0110); check(32'(analogOutput));
      power[3] = 1'b1;
      wait_pe(1000);

      // Prescale 3: period 1024, duty 128 high for 512 clocks
      prescale = 8'd3;
      wr(2, 128);
      wait_pe(2000);
      wait_pe(2000);
      push("ps3_period", 1024); check(32'(n_clk));
      push("ps3_ch2_hi", 512);  check(32'(hi[2]));

      // Prescale 9 -> 2 at pdiv=7: tick on next edge, so 1+254*3+3 = 766
      prescale = 8'd9;
      step(7);
      prescale = 8'd2;
      wait_pe(2000);
      push("ps_switch_clk", 766); check(32'(n_clk));

      // Asynchronous reset mid-period loses outputs and pending shadows
      step(50);
      push("pre_rst_out", 4'b1110); check(32'(analogOutput));
      wr(0, 50);
      push("pre_rst_pend", 4'b0001); check(32'(pending));
      #2 reset = 1'b0;
      #1;
      push("async_rst_out", 0);   check(32'(analogOutput));
      push("async_rst_pend", 0);  check(32'(pending));
      push("async_rst_ready", 0); check(32'(wr_ready));
      step(3);
      prescale = 8'd0;
      reset    = 1'b1;
      wait_pe(1000);
      push("rerun_pe_clk", 256); check(32'(n_clk));
      push("rerun_hi", 0);       check(32'(hi[0] + hi[1] + hi[2] + hi[3]));

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
`default_nettype wire
